// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
// Sequencing controller and datapath for an iterative radix-2 restoring
// divider serving MIPS DIV/DIVU in the EX stage. One quotient bit is produced
// per cycle. The quotient goes to LO and the remainder to HI, qualified by a
// one-cycle valid pulse. busy stalls the pipeline while an operation is
// accepted or running.
//
// Optional feature (compile-time macro DIV_EARLY_EXIT_EN):
//   When defined, a nonzero divisor whose magnitude exceeds the dividend
//   magnitude skips the RUN phase and completes in the cycle after accept.
//   Results are identical with or without the macro; only latency differs.
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CW-1:0]    cnt;       // iterations completed in RUN
  logic [WIDTH-1:0] prem;      // partial remainder
  logic [WIDTH-1:0] dvd;       // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs;       // divisor magnitude
  logic             neg_q;     // negate quotient at the end
  logic             neg_r;     // negate remainder at the end
  logic             div_zero;  // divide-by-zero: bypass sign correction
  logic [WIDTH-1:0] q_hold;    // last committed quotient
  logic [WIDTH-1:0] r_hold;    // last committed remainder

  logic             accept;
  logic             b_zero;
  logic             early_exit;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  // Operand magnitudes: signed ops take absolute values, unsigned pass through.
  assign mag_a  = (sign_div && a[WIDTH-1]) ? (~a + ONE) : a;
  assign mag_b  = (sign_div && b[WIDTH-1]) ? (~b + ONE) : b;
  assign b_zero = (b == '0);

  // A request is taken only from IDLE, and never when flushed or in reset.
  assign accept = (state == S_IDLE) && start && !annul && !rst;

`ifdef DIV_EARLY_EXIT_EN
  assign early_exit = !b_zero && (mag_a < mag_b);
`else
  assign early_exit = 1'b0;
`endif

  // One restoring step: shift the next dividend bit into the partial
  // remainder, then trial-subtract. Bit WIDTH of the difference is the borrow:
  // because prem < dvs, a non-borrowing result always fits in WIDTH bits.
  assign shifted = {prem, dvd[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign q_bit   = ~diff[WIDTH];
  assign rem_nxt = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

  // Final sign correction; a zero divisor returns the raw operands untouched.
  assign q_fin = (!div_zero && neg_q) ? (~dvd  + ONE) : dvd;
  assign r_fin = (!div_zero && neg_r) ? (~prem + ONE) : prem;

  // Results are shown live in the DONE cycle and held from the registers after.
  assign valid     = (state == S_DONE);
  assign quotient  = valid ? q_fin : q_hold;
  assign remainder = valid ? r_fin : r_hold;

  // Stall while accepting or iterating; released in DONE so the pipeline
  // advances together with the valid pulse.
  assign busy = accept || (state == S_RUN);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = (b_zero || early_exit) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (annul)             state_nxt = S_IDLE;
        else if (cnt == LAST)  state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, per-cycle iteration and result commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      prem     <= '0;
      dvd      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      q_hold   <= '0;
      r_hold   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            cnt   <= '0;
            dvs   <= mag_b;
            neg_q <= sign_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= sign_div & a[WIDTH-1];
            if (b_zero) begin
              // Quotient all ones, remainder is the dividend as given.
              div_zero <= 1'b1;
              prem     <= a;
              dvd      <= '1;
            end else if (early_exit) begin
              // Quotient is zero and the whole dividend is the remainder.
              div_zero <= 1'b0;
              prem     <= mag_a;
              dvd      <= '0;
            end else begin
              div_zero <= 1'b0;
              prem     <= '0;
              dvd      <= mag_a;
            end
          end
        end
        S_RUN: begin
          prem <= rem_nxt;
          dvd  <= {dvd[WIDTH-2:0], q_bit};
          cnt  <= cnt + 1'b1;
        end
        S_DONE: begin
          q_hold <= q_fin;
          r_hold <= r_fin;
        end
        default: ;
      endcase
    end
  end

endmodule
